// File: rtl/buzzer_pkg.sv
// buzzer_pkg: shared definitions for the buzzer scheduler.
//   - note code constants (0 = rest, 1..5 = C6, D6, E6, G6, A6)
//   - scheduler FSM state encoding
//   - half-period lookup (note code -> 15-bit tone counter limit)
//   - 16-entry melody ROM
package buzzer_pkg;

  localparam logic [2:0] NOTE_REST = 3'd0;
  localparam logic [2:0] NOTE_C6   = 3'd1;
  localparam logic [2:0] NOTE_D6   = 3'd2;
  localparam logic [2:0] NOTE_E6   = 3'd3;
  localparam logic [2:0] NOTE_G6   = 3'd4;
  localparam logic [2:0] NOTE_A6   = 3'd5;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MANUAL    = 2'd1,
    ST_PLAY_NOTE = 2'd2,
    ST_PLAY_GAP  = 2'd3
  } state_t;

  // Entry [0] is played first; written most-significant first.
  localparam logic [15:0][2:0] SONG_ROM = {
    3'd0, 3'd5, 3'd4, 3'd3,
    3'd0, 3'd5, 3'd4, 3'd3,
    3'd1, 3'd3, 3'd2, 3'd1,
    3'd1, 3'd3, 3'd2, 3'd1
  };

  // Counter limit H; the tone period is 2*(H+1) cycles of the 50 MHz clock.
  function automatic logic [14:0] half_period(input logic [2:0] code);
    case (code)
      NOTE_C6: half_period = 15'd23888;
      NOTE_D6: half_period = 15'd21282;
      NOTE_E6: half_period = 15'd18960;
      NOTE_G6: half_period = 15'd15943;
      NOTE_A6: half_period = 15'd14204;
      default: half_period = 15'd0;
    endcase
  endfunction

endpackage

// File: rtl/buzzer_sched_tone_gen.sv
// tone_gen: square-wave generator for one note code.
//   clk, rst_n : clock, asynchronous active-low reset
//   note_code  : 0 = silence, 1..5 = note to sound
//   sound      : registered square wave, always starts in the low phase
module tone_gen
  import buzzer_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] note_code,
  output logic       sound
);

  logic [14:0] cnt;
  logic [2:0]  code_q;
  logic [14:0] half;

  assign half = half_period(note_code);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      code_q <= NOTE_REST;
      sound  <= 1'b0;
    end else begin
      code_q <= note_code;
      // A new note restarts from a clean low phase, so no partial first
      // half-cycle leaks over from the previous note.
      if ((note_code != code_q) || (note_code == NOTE_REST)) begin
        cnt   <= '0;
        sound <= 1'b0;
      end else if (cnt == half) begin
        cnt   <= '0;
        sound <= ~sound;
      end else begin
        cnt <= cnt + 15'd1;
      end
    end
  end

endmodule

// File: rtl/buzzer_sched.sv
// buzzer_sched: single-voice buzzer scheduler.
//   clk, rst_n  : 50 MHz clock, asynchronous active-low reset
//   key[4:0]    : held note buttons (async), key[0]=A6 highest priority
//   play_start  : one-cycle pulse, start the ROM melody from step 0
//   play_stop   : one-cycle pulse, abort the melody
//   busy        : registered, high while the melody is playing
//   note_code   : registered current note (0 = silence)
//   sound       : buzzer square wave
//
// state        | meaning
// -------------+------------------------------------------------
// ST_IDLE      | silent, waiting for a key or play_start
// ST_MANUAL    | a key is held, note follows the key arbiter
// ST_PLAY_NOTE | melody step sounding for NOTE_TICKS cycles
// ST_PLAY_GAP  | silent gap of GAP_TICKS cycles after each step
module buzzer_sched
  import buzzer_pkg::*;
#(
  parameter int NOTE_TICKS = 12500000,
  parameter int GAP_TICKS  = 1250000,
  parameter int SONG_LEN   = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [4:0] key,
  input  logic       play_start,
  input  logic       play_stop,
  output logic       busy,
  output logic [2:0] note_code,
  output logic       sound
);

  localparam logic [23:0] NOTE_LAST = 24'(NOTE_TICKS - 1);
  localparam logic [23:0] GAP_LAST  = 24'(GAP_TICKS - 1);
  localparam logic [3:0]  STEP_LAST = 4'(SONG_LEN - 1);

  logic [4:0]  key_s1;
  logic [4:0]  ks;
  logic [2:0]  arb_code;
  state_t      state;
  logic [3:0]  step;
  logic [3:0]  step_nxt;
  logic [23:0] dur;

  assign step_nxt = step + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_s1 <= '0;
      ks     <= '0;
    end else begin
      key_s1 <= key;
      ks     <= key_s1;
    end
  end

  // Highest pitch wins.
  always_comb begin
    arb_code = NOTE_REST;
    if      (ks[0]) arb_code = NOTE_A6;
    else if (ks[1]) arb_code = NOTE_G6;
    else if (ks[2]) arb_code = NOTE_E6;
    else if (ks[3]) arb_code = NOTE_D6;
    else if (ks[4]) arb_code = NOTE_C6;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      step      <= '0;
      dur       <= '0;
      busy      <= 1'b0;
      note_code <= NOTE_REST;
    end else begin
      case (state)
        ST_IDLE: begin
          if (ks != '0) begin
            state     <= ST_MANUAL;
            note_code <= arb_code;
          end else if (play_start) begin
            state     <= ST_PLAY_NOTE;
            step      <= '0;
            dur       <= '0;
            busy      <= 1'b1;
            note_code <= SONG_ROM[0];
          end
        end
        ST_MANUAL: begin
          if (ks == '0) begin
            state     <= ST_IDLE;
            note_code <= NOTE_REST;
          end else begin
            note_code <= arb_code;
          end
        end
        ST_PLAY_NOTE, ST_PLAY_GAP: begin
          // Keys pre-empt playback, then play_stop, then normal sequencing.
          if (ks != '0) begin
            state     <= ST_MANUAL;
            step      <= '0;
            dur       <= '0;
            busy      <= 1'b0;
            note_code <= arb_code;
          end else if (play_stop) begin
            state     <= ST_IDLE;
            step      <= '0;
            dur       <= '0;
            busy      <= 1'b0;
            note_code <= NOTE_REST;
          end else if (state == ST_PLAY_NOTE) begin
            if (dur == NOTE_LAST) begin
              dur       <= '0;
              state     <= ST_PLAY_GAP;
              note_code <= NOTE_REST;
            end else begin
              dur <= dur + 24'd1;
            end
          end else begin
            if (dur == GAP_LAST) begin
              dur <= '0;
              if (step == STEP_LAST) begin
                state <= ST_IDLE;
                step  <= '0;
                busy  <= 1'b0;
              end else begin
                step      <= step_nxt;
                state     <= ST_PLAY_NOTE;
                note_code <= SONG_ROM[step_nxt];
              end
            end else begin
              dur <= dur + 24'd1;
            end
          end
        end
        default: begin
          state     <= ST_IDLE;
          busy      <= 1'b0;
          note_code <= NOTE_REST;
        end
      endcase
    end
  end

  tone_gen u_tone (
    .clk       (clk),
    .rst_n     (rst_n),
    .note_code (note_code),
    .sound     (sound)
  );

endmodule
